// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the synchronous counter family: state encodings and default width.
// Also imported by the up-counter bench when it checks states.
package sync_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter/timer with a one-cycle terminal-count pulse.
// Optional macro AUTO_RELOAD_EN turns underflow into a reload for periodic operation.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] next_count;
    logic             tc_q;
    logic             next_tc;
    logic             underflow_state_run;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] next_reload;
    logic [WIDTH-1:0] underflow_count;

    assign underflow_count     = reload;
    assign underflow_state_run = 1'b1;
`else
    logic [WIDTH-1:0] underflow_count;

    assign underflow_count     = ZERO;
    assign underflow_state_run = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= ALL_ONES;
            tc_q  <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            tc_q  <= next_tc;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            reload <= ALL_ONES;
        end else begin
            reload <= next_reload;
        end
    end

    always_comb begin
        next_reload = reload;
        if (load) begin
            next_reload = load_val;
        end
    end
`endif

    // Priority is load over en; an enabled edge at zero is the underflow that fires tc.
    always_comb begin
        next_state = state;
        next_count = count;
        next_tc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    next_count = load_val;
                end else if (en) begin
                    if (count != ZERO) begin
                        next_state = ST_RUN;
                        next_count = count - ONE;
                    end else begin
                        next_tc    = 1'b1;
                        next_count = underflow_count;
                        next_state = underflow_state_run ? ST_RUN : ST_EXPIRED;
                    end
                end
            end
            ST_RUN: begin
                if (load) begin
                    next_count = load_val;
                end else if (en) begin
                    if (count != ZERO) begin
                        next_count = count - ONE;
                    end else begin
                        next_tc    = 1'b1;
                        next_count = underflow_count;
                        next_state = underflow_state_run ? ST_RUN : ST_EXPIRED;
                    end
                end
            end
            ST_EXPIRED: begin
                next_count = ZERO;
                if (load) begin
                    next_count = load_val;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_count = ALL_ONES;
            end
        endcase
    end

    assign q    = count;
    assign tc   = tc_q;
    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter; build with AUTO_RELOAD_EN defined
// to exercise the periodic-reload variant.
module tb_sync_down_counter;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic [3:0] q;
    logic       tc;
    logic       busy;

    int tests_run;
    int tests_failed;

    sync_down_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .q        (q),
        .tc       (tc),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, so outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [3:0] exp_q,
                               input logic exp_tc, input logic exp_busy);
        tests_run++;
        if (q !== exp_q || tc !== exp_tc || busy !== exp_busy) begin
            tests_failed++;
            $display("[TB] FAIL %s: got q=%h tc=%b busy=%b, expected q=%h tc=%b busy=%b",
                     name, q, tc, busy, exp_q, exp_tc, exp_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; load_val = 4'h0; en = 1'b0;
        tick();
        tick();
        check_state("reset_two_edges", 4'hF, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        check_state("reset_overrides_en", 4'hF, 1'b0, 1'b0);
    endtask

    task automatic test_full_count();
        reset = 1'b0; en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            tests_run++;
            if (q !== 4'(15 - k) || tc !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL full_count_step%0d: got q=%h tc=%b busy=%b, expected q=%h tc=0 busy=1",
                         k, q, tc, busy, 4'(15 - k));
            end
        end
        tick();
`ifdef AUTO_RELOAD_EN
        check_state("full_count_underflow", 4'hF, 1'b1, 1'b1);
        tick();
        check_state("full_count_after_reload", 4'hE, 1'b0, 1'b1);
`else
        check_state("full_count_underflow", 4'h0, 1'b1, 1'b0);
        tick();
        check_state("full_count_expired_hold", 4'h0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_load_idle();
        reset = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        reset = 1'b0; load = 1'b1; load_val = 4'h3;
        tick();
        check_state("load_in_idle", 4'h3, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick();
        check_state("load3_edge1", 4'h2, 1'b0, 1'b1);
        tick();
        check_state("load3_edge2", 4'h1, 1'b0, 1'b1);
        tick();
        check_state("load3_edge3", 4'h0, 1'b0, 1'b1);
        tick();
`ifdef AUTO_RELOAD_EN
        check_state("load3_tc", 4'h3, 1'b1, 1'b1);
        tick();
        check_state("load3_period_e5", 4'h2, 1'b0, 1'b1);
        tick();
        check_state("load3_period_e6", 4'h1, 1'b0, 1'b1);
        tick();
        check_state("load3_period_e7", 4'h0, 1'b0, 1'b1);
        tick();
        check_state("load3_second_tc", 4'h3, 1'b1, 1'b1);
`else
        check_state("load3_tc", 4'h0, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_pause();
        reset = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        reset = 1'b0; load = 1'b1; load_val = 4'hA;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        check_state("pause_enter_run", 4'h9, 1'b0, 1'b1);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (q !== 4'h9 || busy !== 1'b1 || tc !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL pause_hold%0d: got q=%h busy=%b tc=%b, expected q=9 busy=1 tc=0",
                         k, q, busy, tc);
            end
        end
        en = 1'b1;
        tick();
        check_state("pause_resume", 4'h8, 1'b0, 1'b1);
    endtask

    task automatic test_load_during_run();
        en = 1'b1; load = 1'b0;
        tick();
        tick();
        tick();
        check_state("run_reach5", 4'h5, 1'b0, 1'b1);
        load = 1'b1; load_val = 4'hC;
        tick();
        check_state("run_load_beats_en", 4'hC, 1'b0, 1'b1);
        load = 1'b0;
        tick();
        check_state("run_after_load", 4'hB, 1'b0, 1'b1);
    endtask

    task automatic test_expired_and_abort();
        load = 1'b1; load_val = 4'h0; en = 1'b0;
        tick();
        check_state("load_zero_run", 4'h0, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1;
        tick();
`ifdef AUTO_RELOAD_EN
        check_state("zero_underflow_reload", 4'h0, 1'b1, 1'b1);
        tick();
        check_state("zero_reload_again", 4'h0, 1'b1, 1'b1);
        load = 1'b1; load_val = 4'h2; en = 1'b0;
        tick();
        check_state("reload_load2", 4'h2, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1;
        tick();
`else
        check_state("zero_underflow", 4'h0, 1'b1, 1'b0);
        tick();
        check_state("expired_ignores_en", 4'h0, 1'b0, 1'b0);
        load = 1'b1; load_val = 4'h2; en = 1'b0;
        tick();
        check_state("expired_load_to_idle", 4'h2, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick();
`endif
        check_state("abort_at_1", 4'h1, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        check_state("abort_reset", 4'hF, 1'b0, 1'b0);
        reset = 1'b0; en = 1'b0;
        tick();
        check_state("abort_no_tc", 4'hF, 1'b0, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1; load = 1'b0; load_val = 4'h0; en = 1'b0;
        #1;
        test_reset();
        test_full_count();
        test_load_idle();
        test_pause();
        test_load_during_run();
        test_expired_and_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
